// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared owner encoding and memory depth for the data-memory arbiter
package dmem_pkg;
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_AUX  = 2'd2;
  localparam int DMEM_DEPTH = 256;
endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational CPU/AUX grant decision
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed CPU priority with a starvation override.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic       cpu_req,
  input  logic       aux_req,
`ifdef DMEM_ARB_RR_EN
  input  logic [1:0] last_owner,
`else
  input  logic       starve,
`endif
  output logic       cpu_gnt,
  output logic       aux_gnt
);

  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
`ifdef DMEM_ARB_RR_EN
    // On contention the side that did not own the previous cycle wins; IDLE favours the CPU.
    if (cpu_req && aux_req) begin
      if (last_owner == OWN_CPU) aux_gnt = 1'b1;
      else                       cpu_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_req;
      aux_gnt = aux_req;
    end
`else
    if (aux_req && starve) aux_gnt = 1'b1;
    else if (cpu_req)      cpu_gnt = 1'b1;
    else                   aux_gnt = aux_req;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the CPU MEM stage and AUX
// DMEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority with starvation guard.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    last_owner_q, last_owner_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] aux_rdata_q, aux_rdata_d;
  logic          pick_cpu, pick_aux;

`ifndef DMEM_ARB_RR_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  logic [WW-1:0] aux_wait_q, aux_wait_d;
  logic          starve;

  assign starve = (aux_wait_q == WW'(STARVE_LIMIT));
`endif

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .aux_req    (aux_req),
`ifdef DMEM_ARB_RR_EN
    .last_owner (last_owner_q),
`else
    .starve     (starve),
`endif
    .cpu_gnt    (pick_cpu),
    .aux_gnt    (pick_aux)
  );

  // Grants drop the instant reset rises, so nothing reaches memory during reset.
  assign cpu_gnt   = pick_cpu & ~rst;
  assign aux_gnt   = pick_aux & ~rst;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (aux_gnt) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_we    = aux_we;
      mem_re    = ~aux_we;
    end
  end

  always_comb begin
    last_owner_d = OWN_IDLE;
    if (cpu_gnt)      last_owner_d = OWN_CPU;
    else if (aux_gnt) last_owner_d = OWN_AUX;
    rd_pend_d   = mem_re;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    if (cpu_gnt && !cpu_we) cpu_rdata_d = mem_rdata;
    if (aux_gnt && !aux_we) aux_rdata_d = mem_rdata;
  end

`ifndef DMEM_ARB_RR_EN
  always_comb begin
    aux_wait_d = aux_wait_q;
    if (!aux_req || aux_gnt)                aux_wait_d = '0;
    else if (aux_wait_q != WW'(STARVE_LIMIT)) aux_wait_d = aux_wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) aux_wait_q <= '0;
    else     aux_wait_q <= aux_wait_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_IDLE;
      rd_pend_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      aux_rdata_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      cpu_rdata_q  <= cpu_rdata_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  // The previous cycle's owner tells us whose read is returning now.
  assign cpu_rvalid = rd_pend_q & (last_owner_q == OWN_CPU);
  assign aux_rvalid = rd_pend_q & (last_owner_q == OWN_AUX);
  assign cpu_rdata  = cpu_rdata_q;
  assign aux_rdata  = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural memory
// Exercises round-robin instead of fixed priority when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem [DMEM_DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  always @(negedge clk) mem_rdata <= mem[mem_addr[7:0]];

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1; cpu_wdata = '0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'd2; aux_wdata = '0;
    #2;
    n_checks++;
    if ({cpu_gnt, aux_gnt, mem_we, mem_re} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_gnt: got %b expected 0000", {cpu_gnt, aux_gnt, mem_we, mem_re});
    end
    cycle(); cycle();
    n_checks++;
    if ({cpu_rvalid, aux_rvalid} !== 2'b00 || cpu_rdata !== 32'd0 || aux_rdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_rd: rvalid %b rdata %h/%h expected 00 0/0", {cpu_rvalid, aux_rvalid}, cpu_rdata, aux_rdata);
    end
    n_checks++;
    if (mem_addr !== 32'd0) begin
      n_errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd4; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd4 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL cpu_wr: gnt %b we %b addr %h wdata %h expected 1 1 4 deadbeef", cpu_gnt, mem_we, mem_addr, mem_wdata);
    end
    cycle();
    cpu_we = 1'b0;
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || mem_re !== 1'b1 || cpu_gnt !== 1'b1) begin
      n_errors++; $display("FAIL cpu_rd_issue: rvalid %b re %b gnt %b expected 0 1 1", cpu_rvalid, mem_re, cpu_gnt);
    end
    cycle();
    cpu_req = 1'b0;
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL cpu_rd_data: rvalid %b rdata %h expected 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    cycle();
    n_checks++;
    if (cpu_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL cpu_rvalid_pulse: got %b expected 0", cpu_rvalid);
    end
  endtask

  task automatic test_arbitration();
    logic exp_cpu, exp_rv_cpu, exp_rv_aux;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'd2;
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_cpu    = (i % 2 == 0);
      exp_rv_cpu = (i > 0) && ((i - 1) % 2 == 0);
`else
      exp_cpu    = (i % 5 != 4);
      exp_rv_cpu = (i > 0) && ((i - 1) % 5 != 4);
`endif
      exp_rv_aux = (i > 0) && !exp_rv_cpu;
      #1;
      n_checks++;
      if ({cpu_gnt, aux_gnt, cpu_stall} !== {exp_cpu, !exp_cpu, !exp_cpu}) begin
        n_errors++; $display("FAIL arb_gnt[%0d]: cpu/aux/stall %b expected %b", i, {cpu_gnt, aux_gnt, cpu_stall}, {exp_cpu, !exp_cpu, !exp_cpu});
      end
      n_checks++;
      if (mem_addr !== (exp_cpu ? 32'd1 : 32'd2)) begin
        n_errors++; $display("FAIL arb_addr[%0d]: got %h expected %h", i, mem_addr, exp_cpu ? 32'd1 : 32'd2);
      end
      n_checks++;
      if ({cpu_rvalid, aux_rvalid} !== {exp_rv_cpu, exp_rv_aux}) begin
        n_errors++; $display("FAIL arb_rvalid[%0d]: got %b expected %b", i, {cpu_rvalid, aux_rvalid}, {exp_rv_cpu, exp_rv_aux});
      end
      cycle();
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    cycle();
  endtask

  task automatic test_aux_write_cpu_read();
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'd9; aux_wdata = 32'd5;
    #1;
    n_checks++;
    if (aux_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd9) begin
      n_errors++; $display("FAIL aux_wr: gnt %b we %b addr %h expected 1 1 9", aux_gnt, mem_we, mem_addr);
    end
    cycle();
    aux_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
    #1;
    n_checks++;
    if (aux_rvalid !== 1'b0 || cpu_gnt !== 1'b1) begin
      n_errors++; $display("FAIL aux_wr_norv: aux_rvalid %b cpu_gnt %b expected 0 1", aux_rvalid, cpu_gnt);
    end
    cycle();
    cpu_req = 1'b0;
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd5 || aux_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL raw_fwd: cpu_rvalid %b rdata %h aux_rvalid %b expected 1 5 0", cpu_rvalid, cpu_rdata, aux_rvalid);
    end
    cycle();
  endtask

  task automatic test_reset_mid_read();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'd4;
    #1;
    n_checks++;
    if (aux_gnt !== 1'b1 || mem_re !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre: aux_gnt %b re %b expected 1 1", aux_gnt, mem_re);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({aux_gnt, aux_rvalid, mem_re} !== 3'b000) begin
      n_errors++; $display("FAIL mid_rst: gnt/rvalid/re %b expected 000", {aux_gnt, aux_rvalid, mem_re});
    end
    cycle();
    rst = 1'b0; aux_req = 1'b0;
    n_checks++;
    if (aux_rvalid !== 1'b0 || aux_rdata !== 32'd0 || dut.last_owner_q !== OWN_IDLE) begin
      n_errors++; $display("FAIL mid_post: rvalid %b rdata %h owner %0d expected 0 0 0", aux_rvalid, aux_rdata, dut.last_owner_q);
    end
    cycle();
    n_checks++;
    if (aux_rvalid !== 1'b0 || dut.last_owner_q !== OWN_IDLE) begin
      n_errors++; $display("FAIL mid_after: rvalid %b owner %0d expected 0 0", aux_rvalid, dut.last_owner_q);
    end
  endtask

  task automatic test_idle();
    cpu_req = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if ({mem_we, mem_re, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, cpu_stall} !== 7'b0 || mem_addr !== 32'd0) begin
        n_errors++; $display("FAIL idle[%0d]: ctl %b addr %h expected 0 0", i, {mem_we, mem_re, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, cpu_stall}, mem_addr);
      end
      cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) mem[i] = '0;
    mem_rdata = '0;
    test_reset();
    test_cpu_write_read();
    test_arbitration();
    test_aux_write_cpu_read();
    test_reset_mid_read();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
